mini_subsystem_v2: RTL and testbench
====================================

Name: mini_subsystem_v2

Overview:
Parametrised successor to the mini subsystem: an N-bit accumulator ALU feeding a DEPTH-deep FIFO, with a valid/ready input handshake, credit-based backpressure, a registered read port and sticky error flags. It sits between an external data source and a downstream consumer that drains results through fifo_rd. One ALU pipeline stage sits ahead of the buffer.

Parameters:
N, 8, datapath width (>=4)
DEPTH, 8, FIFO entries; power of two, >=2
ADDR_W, $clog2(DEPTH), derived pointer width; not overridden

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
ext_data  in  N  operand A
alu_sel  in  3  opcode (alu_op_e), sampled with in_valid
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
fifo_rd  in  1  read request
fifo_out  out  N  registered read data
fifo_carry  out  1  carry/borrow stored with fifo_out
out_valid  out  1  one-cycle pulse: fifo_out/fifo_carry updated this cycle
fifo_empty  out  1  no stored entries
fifo_full  out  1  count == DEPTH
fifo_count  out  ADDR_W+1  stored entries
clr_err  in  1  clears sticky errors
err_underflow  out  1  sticky: fifo_rd while empty

Behaviour:
- Reset (rst=0, async): acc=0, stage invalid, pointers/count=0, fifo_out=0, fifo_carry=0, out_valid=0, err_underflow=0, fifo_empty=1, fifo_full=0, in_ready=1 after release.
- Accept: beat taken at a rising edge when in_valid && in_ready. B operand = acc.
- Opcodes: 000 ADD A+B; 001 SUB B-A; 010 AND; 011 OR; 100 XOR; 101 PASS A; 110 SHL A by 1; 111 SHR A by 1 (logical). Computed at N+1 bits; result = low N bits; carry = bit N for ADD, borrow (A>B) for SUB, shifted-out bit for SHL/SHR, 0 otherwise.
- On accept: acc <= result; stage register <= {carry,result}, stage valid=1. Without accept: stage valid=0, acc holds.
- Stage writes into FIFO on the next edge: beat accepted at edge k is visible in fifo_count/fifo_empty after edge k+1.
- in_ready = (fifo_count + stage_valid) < DEPTH, combinational; counts the pending write so no beat is ever dropped. No overflow condition exists.
- Read: fifo_rd && !fifo_empty at edge k -> fifo_out/fifo_carry <= head entry, out_valid=1 during cycle k..k+1, rd_ptr++ (wraps modulo DEPTH). Otherwise out_valid=0 and fifo_out holds.
- fifo_rd while empty: ignored, err_underflow <= 1. clr_err clears it; a new underflow in the same cycle as clr_err wins (stays 1).
- Simultaneous write and read: count unchanged, both pointers advance; legal when full (read frees the slot, write fills it) and when count=1.
- Pointer wrap: wr_ptr/rd_ptr wrap DEPTH-1 -> 0. full/empty derive from fifo_count.
- Order: FIFO output order equals accept order.
- Reset mid-operation: all state, including stored entries and pending stage, is discarded immediately.

Decomposition:
- Package mini_subsystem_pkg: alu_op_e enum (ADD..SHR, 3 bits); function alu_compute(a,b,op) returning {carry,result}, width-parametrised via N passed in.
- Sub-module ss_fifo (DEPTH, W=N+1): storage, pointers, count, registered read, underflow flag. Top holds the ALU stage, accumulator and handshake.

Test Plan:
- Reset: rst=0 mid-run with 3 entries stored -> immediately fifo_empty=1, fifo_count=0, fifo_out=0, err_underflow=0; acc=0 (next ADD 7 stores 7).
- Accumulate: ext_data=5, ADD, 3 beats, then 3 reads -> fifo_out 5,10,15 in order, carry 0, one out_valid pulse each.
- Carry/borrow: ADD 200 twice -> 200/c0 then 144/c1; then PASS 3, SUB 5 -> 3 then 254/c1.
- Backpressure (DEPTH=4): in_valid held, no reads -> exactly 4 beats accepted, in_ready=0, fifo_full=1, fifo_count=4; one read -> in_ready=1 next cycle; no data lost.
- Full plus simultaneous read/write: with count=4, fifo_rd and an accepted beat landing on the same edge -> count stays 4, output order preserved across pointer wrap.
- Underflow: fifo_rd while empty -> err_underflow=1, fifo_out unchanged, out_valid=0; clr_err=1 -> 0; clr_err and underflow on the same edge -> stays 1.

Source files
------------

// File: rtl/mini_subsystem_pkg.sv
// Shared types and the accumulator ALU function for mini_subsystem_v2.
// The ALU is evaluated on a fixed wide datapath and trimmed to the caller's width.
package mini_subsystem_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_PASS = 3'b101,
        ALU_SHL  = 3'b110,
        ALU_SHR  = 3'b111
    } alu_op_e;

    localparam int ALU_MAX_W = 64;

    // Returns {carry, result} with the carry placed at bit n; bits above n are zero.
    function automatic logic [ALU_MAX_W:0] alu_compute(
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b,
        input alu_op_e              op,
        input int unsigned          n
    );
        logic [ALU_MAX_W:0]   wide;
        logic [ALU_MAX_W-1:0] mask;
        logic [ALU_MAX_W:0]   ret;
        logic                 carry;
        logic [6:0]           n_bit;
        logic [5:0]           msb_bit;

        n_bit   = 7'(n);
        msb_bit = 6'(n - 1);
        mask    = {ALU_MAX_W{1'b1}} >> (7'(ALU_MAX_W) - n_bit);
        wide    = '0;
        carry   = 1'b0;
        case (op)
            ALU_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                carry = wide[n_bit];
            end
            ALU_SUB: begin
                wide  = {1'b0, b} - {1'b0, a};
                carry = (a > b);
            end
            ALU_AND:  wide = {1'b0, a & b};
            ALU_OR:   wide = {1'b0, a | b};
            ALU_XOR:  wide = {1'b0, a ^ b};
            ALU_PASS: wide = {1'b0, a};
            ALU_SHL: begin
                wide  = {1'b0, a << 1};
                carry = a[msb_bit];
            end
            ALU_SHR: begin
                wide  = {1'b0, a >> 1};
                carry = a[0];
            end
            default: wide = '0;
        endcase
        ret        = {1'b0, wide[ALU_MAX_W-1:0] & mask};
        ret[n_bit] = carry;
        return ret;
    endfunction

endpackage

// File: rtl/ss_fifo.sv
// Circular buffer with registered read port, occupancy count and sticky underflow flag.
// Overflow is prevented upstream, so a write is always assumed to have a free slot.
module ss_fifo #(
    parameter int DEPTH  = 8,
    parameter int W      = 9,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [W-1:0]      wr_data,
    input  logic              rd_req,
    input  logic              clr_err,
    output logic [W-1:0]      rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              err_underflow
);
    import mini_subsystem_pkg::*;

    localparam int CNT_W = ADDR_W + 1;

    logic [W-1:0]      mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [W-1:0]      rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;
    logic              rd_fire;
    logic              underflow;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign rd_fire   = rd_req && !empty;
    assign underflow = rd_req && empty;

    // NOTE: every variable gets a default before any branch, so no path leaves
    // a combinational output unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = err_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_fire) begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end

        case ({wr_en, rd_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A fresh underflow outranks a clear arriving on the same edge.
        if (underflow) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others regardless of evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers and count is
    // enough to discard its contents, and it keeps the array mappable to RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign count         = count_q;
    assign err_underflow = err_q;

endmodule

// File: rtl/mini_subsystem_v2.sv
// Accumulator ALU with valid/ready intake and one pipeline stage, feeding ss_fifo.
// in_ready counts the in-flight stage entry so an accepted beat always has a slot.
module mini_subsystem_v2 #(
    parameter int N      = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      ext_data,
    input  logic [2:0]        alu_sel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              fifo_rd,
    output logic [N-1:0]      fifo_out,
    output logic              fifo_carry,
    output logic              out_valid,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [ADDR_W:0]   fifo_count,
    input  logic              clr_err,
    output logic              err_underflow
);
    import mini_subsystem_pkg::*;

    localparam int CNT_W = ADDR_W + 1;

    logic [N-1:0]     acc_q, acc_d;
    logic             stage_valid_q, stage_valid_d;
    logic [N:0]       stage_data_q, stage_data_d;
    logic [N:0]       alu_res;
    logic [CNT_W-1:0] occupancy;
    logic             accept;
    logic [N:0]       rd_word;

    // Occupancy never exceeds DEPTH+1, which still fits in CNT_W bits for DEPTH>=2.
    assign occupancy = fifo_count + CNT_W'(stage_valid_q);
    assign in_ready  = (occupancy < CNT_W'(DEPTH));
    assign accept    = in_valid && in_ready;

    assign alu_res = (N+1)'(alu_compute(ALU_MAX_W'(ext_data), ALU_MAX_W'(acc_q),
                                        alu_op_e'(alu_sel), N));

    always_comb begin
        acc_d         = acc_q;
        stage_data_d  = stage_data_q;
        stage_valid_d = accept;
        if (accept) begin
            acc_d        = alu_res[N-1:0];
            stage_data_d = alu_res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q         <= '0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
        end else begin
            acc_q         <= acc_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
        end
    end

    ss_fifo #(
        .DEPTH  (DEPTH),
        .W      (N + 1),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (stage_valid_q),
        .wr_data       (stage_data_q),
        .rd_req        (fifo_rd),
        .clr_err       (clr_err),
        .rd_data       (rd_word),
        .rd_valid      (out_valid),
        .empty         (fifo_empty),
        .full          (fifo_full),
        .count         (fifo_count),
        .err_underflow (err_underflow)
    );

    assign fifo_out   = rd_word[N-1:0];
    assign fifo_carry = rd_word[N];

endmodule

// File: tb/tb_mini_subsystem_v2.sv
// Randomised and directed bench for mini_subsystem_v2 against a queue-based reference model.
module tb_mini_subsystem_v2;
    localparam int N      = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int M      = 1 << N;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      ext_data;
    logic [2:0]        alu_sel;
    logic              in_valid;
    logic              in_ready;
    logic              fifo_rd;
    logic [N-1:0]      fifo_out;
    logic              fifo_carry;
    logic              out_valid;
    logic              fifo_empty;
    logic              fifo_full;
    logic [ADDR_W:0]   fifo_count;
    logic              clr_err;
    logic              err_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [N:0] q[$];
    bit         pend_valid;
    logic [N:0] pend;
    int         acc;
    int         m_out;
    bit         m_carry;
    bit         m_ov;
    bit         m_err;

    mini_subsystem_v2 #(.N(N), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .ext_data      (ext_data),
        .alu_sel       (alu_sel),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .fifo_rd       (fifo_rd),
        .fifo_out      (fifo_out),
        .fifo_carry    (fifo_carry),
        .out_valid     (out_valid),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .fifo_count    (fifo_count),
        .clr_err       (clr_err),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N:0] ref_alu(input int a, input int b, input int op);
        int r;
        bit c;
        logic [N:0] x;
        c = 1'b0;
        case (op)
            0: begin r = (a + b) % M; c = (a + b) >= M; end
            1: begin r = (b - a + M) % M; c = a > b; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a;
            6: begin r = (a * 2) % M; c = a >= M / 2; end
            default: begin r = a / 2; c = (a % 2) == 1; end
        endcase
        x[N-1:0] = r[N-1:0];
        x[N]     = c;
        return x;
    endfunction

    function automatic bit m_ready();
        return (q.size() + int'(pend_valid)) < DEPTH;
    endfunction

    task automatic model_reset();
        q.delete();
        pend_valid = 1'b0;
        pend       = '0;
        acc        = 0;
        m_out      = 0;
        m_carry    = 1'b0;
        m_ov       = 1'b0;
        m_err      = 1'b0;
    endtask

    task automatic model_edge(input bit acc_beat, input int op, input int d, input bit rd, input bit clr);
        logic [N:0] e;
        bit under;
        under = rd && (q.size() == 0);
        m_ov  = 1'b0;
        if (rd && !under) begin
            e       = q.pop_front();
            m_out   = int'(e[N-1:0]);
            m_carry = e[N];
            m_ov    = 1'b1;
        end
        if (under)    m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        if (pend_valid) q.push_back(pend);
        pend_valid = acc_beat;
        if (acc_beat) begin
            pend = ref_alu(d, acc, op);
            acc  = int'(pend[N-1:0]);
        end
    endtask

    task automatic check_outputs();
        check("count", 32'(fifo_count), q.size());
        check("empty", 32'(fifo_empty), 32'(q.size() == 0));
        check("full", 32'(fifo_full), 32'(q.size() == DEPTH));
        check("out", 32'(fifo_out), m_out);
        check("carry", 32'(fifo_carry), 32'(m_carry));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("err", 32'(err_underflow), 32'(m_err));
    endtask

    // Called at a falling edge: drive, check ready, clock once, check results.
    task automatic do_cycle(input bit v, input int op, input int d, input bit rd, input bit clr,
                            output bit accepted);
        bit rdy;
        in_valid = v;
        alu_sel  = 3'(op);
        ext_data = N'(d);
        fifo_rd  = rd;
        clr_err  = clr;
        #1;
        rdy = m_ready();
        check("in_ready", 32'(in_ready), 32'(rdy));
        accepted = v && rdy;
        @(posedge clk);
        model_edge(accepted, op, d, rd, clr);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int cycles);
        bit a;
        for (int i = 0; i < cycles; i++) do_cycle(0, 0, 0, 0, 0, a);
    endtask

    task automatic send(input int op, input int d);
        bit a;
        a = 1'b0;
        for (int i = 0; i < 20 && !a; i++) do_cycle(1, op, d, 0, 0, a);
        if (!a) check("send_timeout", 0, 1);
    endtask

    task automatic read_expect(input string tag, input int val, input bit c);
        bit a;
        do_cycle(0, 0, 0, 1, 0, a);
        check({tag, "_val"}, 32'(fifo_out), val);
        check({tag, "_carry"}, 32'(fifo_carry), 32'(c));
        check({tag, "_pulse"}, 32'(out_valid), 1);
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 4 * DEPTH && q.size() + int'(pend_valid) > 0; i++)
            do_cycle(0, 0, 0, 1, 0, a);
        if (q.size() + int'(pend_valid) != 0) check("drain_timeout", 0, 1);
    endtask

    initial begin
        bit a;
        int accepts;
        int last_out;
        model_reset();
        rst = 1'b0; in_valid = 1'b0; alu_sel = '0; ext_data = '0; fifo_rd = 1'b0; clr_err = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_empty", 32'(fifo_empty), 1);
        check("rst_full", 32'(fifo_full), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_out", 32'(fifo_out), 0);
        check("rst_ov", 32'(out_valid), 0);
        check("rst_err", 32'(err_underflow), 0);
        @(negedge clk);

        // Accumulate 5 three times
        for (int i = 0; i < 3; i++) send(0, 5);
        idle(1);
        read_expect("acc1", 5, 0);
        read_expect("acc2", 10, 0);
        read_expect("acc3", 15, 0);
        idle(1);

        // Carry and borrow
        send(5, 0);
        send(0, 200);
        send(0, 200);
        idle(1);
        read_expect("pass0", 0, 0);
        read_expect("add200", 200, 0);
        read_expect("add400", 144, 1);
        send(5, 3);
        send(1, 5);
        idle(1);
        read_expect("pass3", 3, 0);
        read_expect("sub5", 254, 1);

        // Backpressure: hold in_valid with no reads
        accepts = 0;
        for (int i = 0; i < 10; i++) begin
            do_cycle(1, 0, 1, 0, 0, a);
            if (a) accepts++;
        end
        check("bp_accepts", accepts, DEPTH);
        check("bp_count", 32'(fifo_count), DEPTH);
        check("bp_full", 32'(fifo_full), 1);
        check("bp_ready", 32'(in_ready), 0);
        do_cycle(0, 0, 0, 1, 0, a);
        check("bp_ready_after_rd", 32'(in_ready), 1);
        // Concurrent reads and writes wrapping the pointers
        for (int i = 0; i < 3 * DEPTH; i++) do_cycle(1, 5, 10 + i, 1, 0, a);
        drain();

        // Underflow and clear priority
        last_out = int'(fifo_out);
        do_cycle(0, 0, 0, 1, 0, a);
        check("uf_err", 32'(err_underflow), 1);
        check("uf_ov", 32'(out_valid), 0);
        check("uf_hold", 32'(fifo_out), last_out);
        do_cycle(0, 0, 0, 0, 1, a);
        check("uf_clr", 32'(err_underflow), 0);
        do_cycle(0, 0, 0, 1, 1, a);
        check("uf_clr_race", 32'(err_underflow), 1);
        do_cycle(0, 0, 0, 0, 1, a);

        // Asynchronous reset with stored entries
        for (int i = 0; i < 3; i++) send(0, 9);
        idle(1);
        check("pre_rst_count", 32'(fifo_count), 3);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_empty", 32'(fifo_empty), 1);
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_out", 32'(fifo_out), 0);
        check("mid_rst_err", 32'(err_underflow), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        send(0, 7);
        idle(1);
        read_expect("post_rst", 7, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++)
            do_cycle($urandom_range(0, 99) < 70, $urandom_range(0, 7), $urandom_range(0, M - 1),
                     $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 10, a);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
